hist_gray_acc: RTL and testbench

- Histogram accumulation controller for the grayscale histogram path. It sits directly upstream of the 256-entry dual-port histogram RAM (ram_p) and drives both of its ports.
- Per frame, it counts 8-bit gray pixel values by read-modify-write into that RAM.
- At end of frame it streams out all 256 bin counts and clears each bin as it is read, so the next frame starts from zero.

---
 rtl/hist_gray_acc.sv | 162 ++++++++++++++++
 tb/tb_hist_gray_acc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hist_gray_acc.sv
// Grayscale histogram accumulator: read-modify-write binning into an external
// dual-port RAM, with a read-then-clear dump of all 256 bins at frame end.
module hist_gray_acc #(
    parameter int BITWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic [7:0]          pix_data,
    input  logic                pix_last,
    output logic [7:0]          ram_wraddress,
    output logic                ram_wren,
    output logic [BITWIDTH-1:0] ram_data,
    output logic [7:0]          ram_rdaddress,
    output logic                ram_rden,
    input  logic [BITWIDTH-1:0] ram_q,
    output logic                hist_valid,
    output logic [7:0]          hist_bin,
    output logic [BITWIDTH-1:0] hist_count,
    output logic                hist_last
);

    typedef enum logic [1:0] {CLEAR, ACC, DRAIN, DUMP} state_t;

    state_t              state;
    logic [8:0]          cnt;
    logic                accept;

    logic                s1_vld;
    logic [7:0]          s1_addr;
    logic                s2_vld;
    logic [7:0]          s2_addr;
    logic [BITWIDTH-1:0] s2_val;
    logic                s3_vld;
    logic [7:0]          s3_addr;
    logic [BITWIDTH-1:0] s3_val;

    logic                dmp_vld;
    logic [7:0]          dmp_bin;

    logic [BITWIDTH-1:0] fwd;
    logic [BITWIDTH-1:0] inc;

    assign accept = pix_valid & pix_ready;

    // S2 is being written this cycle; S3 was written on the same edge the
    // RAM sampled S1's read address, so the RAM returned stale data.
    always_comb begin
        if (s2_vld && s2_addr == s1_addr)
            fwd = s2_val;
        else if (s3_vld && s3_addr == s1_addr)
            fwd = s3_val;
        else
            fwd = ram_q;
        inc = (&fwd) ? fwd : fwd + BITWIDTH'(1);
    end

    always_comb begin
        ram_wren      = 1'b0;
        ram_wraddress = '0;
        ram_data      = '0;
        ram_rden      = 1'b0;
        ram_rdaddress = '0;
        if (!rst) begin
            if (state == CLEAR) begin
                ram_wren      = 1'b1;
                ram_wraddress = cnt[7:0];
            end else if (dmp_vld) begin
                ram_wren      = 1'b1;
                ram_wraddress = dmp_bin;
            end else if (s2_vld) begin
                ram_wren      = 1'b1;
                ram_wraddress = s2_addr;
                ram_data      = s2_val;
            end
            if (state == DUMP && !cnt[8]) begin
                ram_rden      = 1'b1;
                ram_rdaddress = cnt[7:0];
            end else if (accept) begin
                ram_rden      = 1'b1;
                ram_rdaddress = pix_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            cnt        <= '0;
            pix_ready  <= 1'b0;
            s1_vld     <= 1'b0;
            s1_addr    <= '0;
            s2_vld     <= 1'b0;
            s2_addr    <= '0;
            s2_val     <= '0;
            s3_vld     <= 1'b0;
            s3_addr    <= '0;
            s3_val     <= '0;
            dmp_vld    <= 1'b0;
            dmp_bin    <= '0;
            hist_valid <= 1'b0;
            hist_bin   <= '0;
            hist_count <= '0;
            hist_last  <= 1'b0;
        end else begin
            s1_vld  <= accept;
            s1_addr <= pix_data;
            s2_vld  <= s1_vld;
            s2_addr <= s1_addr;
            s2_val  <= inc;
            s3_vld  <= s2_vld;
            s3_addr <= s2_addr;
            s3_val  <= s2_val;

            // Dump read k returns on ram_q one cycle later, where it is
            // captured for output and the bin is cleared.
            dmp_vld    <= (state == DUMP) && !cnt[8];
            dmp_bin    <= cnt[7:0];
            hist_valid <= dmp_vld;
            hist_bin   <= dmp_vld ? dmp_bin : 8'd0;
            hist_count <= dmp_vld ? ram_q : '0;
            hist_last  <= dmp_vld && (&dmp_bin);

            case (state)
                CLEAR: begin
                    cnt <= cnt + 9'd1;
                    if (cnt == 9'd255) begin
                        state     <= ACC;
                        pix_ready <= 1'b1;
                        cnt       <= '0;
                    end
                end
                ACC: begin
                    if (accept && pix_last) begin
                        state     <= DRAIN;
                        pix_ready <= 1'b0;
                        cnt       <= '0;
                    end
                end
                DRAIN: begin
                    cnt <= cnt + 9'd1;
                    if (cnt[0]) begin
                        state <= DUMP;
                        cnt   <= '0;
                    end
                end
                DUMP: begin
                    // cnt == 256 is the cycle of the final clear write
                    cnt <= cnt + 9'd1;
                    if (cnt[8]) begin
                        state     <= ACC;
                        pix_ready <= 1'b1;
                        cnt       <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_hist_gray_acc.sv
// Scoreboard bench: two instances (16-bit and 4-bit counters) driven in
// lockstep, each with a behavioural old-data dual-port RAM.
module tb_hist_gray_acc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_valid = 1'b0;
    logic [7:0] pix_data = 8'd0;
    logic pix_last = 1'b0;

    logic        ready_a, wren_a, rden_a, hv_a, hl_a;
    logic [7:0]  wa_a, ra_a, hb_a;
    logic [15:0] wd_a, q_a, hc_a;
    logic        ready_b, wren_b, rden_b, hv_b, hl_b;
    logic [7:0]  wa_b, ra_b, hb_b;
    logic [3:0]  wd_b, q_b, hc_b;

    logic [15:0] mem_a [256];
    logic [3:0]  mem_b [256];

    typedef struct {
        logic [7:0] bin;
        int         c16;
        int         c4;
    } exp_t;

    exp_t sb[$];
    int   model[256];
    int   total = 0;
    int   bad = 0;
    bit   in_dump = 0;

    always #5 clk = ~clk;

    hist_gray_acc #(.BITWIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(ready_a),
        .pix_data(pix_data), .pix_last(pix_last),
        .ram_wraddress(wa_a), .ram_wren(wren_a), .ram_data(wd_a),
        .ram_rdaddress(ra_a), .ram_rden(rden_a), .ram_q(q_a),
        .hist_valid(hv_a), .hist_bin(hb_a), .hist_count(hc_a), .hist_last(hl_a)
    );

    hist_gray_acc #(.BITWIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(ready_b),
        .pix_data(pix_data), .pix_last(pix_last),
        .ram_wraddress(wa_b), .ram_wren(wren_b), .ram_data(wd_b),
        .ram_rdaddress(ra_b), .ram_rden(rden_b), .ram_q(q_b),
        .hist_valid(hv_b), .hist_bin(hb_b), .hist_count(hc_b), .hist_last(hl_b)
    );

    // registered read address, read-during-write returns old data
    always @(posedge clk) begin
        if (wren_a) mem_a[wa_a] <= wd_a;
        if (rden_a) q_a <= mem_a[ra_a];
        if (wren_b) mem_b[wa_b] <= wd_b;
        if (rden_b) q_b <= mem_b[ra_b];
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (hv_a) begin
                if (sb.size() == 0) begin
                    chk("hist_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("hist_bin", hb_a, e.bin);
                    chk("hist_count16", hc_a, e.c16);
                    chk("hist_count4", hc_b, e.c4);
                    chk("hist_valid4", hv_b, 1);
                    chk("hist_last", hl_a, (e.bin == 8'd255) ? 1 : 0);
                    in_dump = 1;
                end
            end else if (in_dump && sb.size() > 0) begin
                chk("hist_gap", hv_a, 1);
            end
            if (sb.size() == 0) in_dump = 0;
        end
    end

    // Assert reset for one cycle, then verify the 256-cycle CLEAR sweep.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        pix_valid = 1'b0;
        pix_last = 1'b0;
        sb.delete();
        in_dump = 0;
        for (int b = 0; b < 256; b++) model[b] = 0;
        @(negedge clk);
        chk("rst_wren", wren_a, 0);
        chk("rst_rden", rden_a, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("rst_hist_valid", hv_a, 0);
                chk("rst_hist_bin", hb_a, 0);
                chk("rst_hist_count", hc_a, 0);
                chk("rst_hist_last", hl_a, 0);
            end
            chk("clr_ready16", ready_a, 0);
            chk("clr_ready4", ready_b, 0);
            chk("clr_wren", wren_a, 1);
            chk("clr_addr", wa_a, i);
            chk("clr_data", wd_a, 0);
        end
        @(negedge clk);
        chk("ready_after_clr", ready_a, 1);
        @(posedge clk); #1;
    endtask

    task automatic push_frame();
        exp_t e;
        for (int b = 0; b < 256; b++) begin
            e.bin = 8'(b);
            e.c16 = sat(model[b], 65535);
            e.c4  = sat(model[b], 15);
            sb.push_back(e);
            model[b] = 0;
        end
    endtask

    // Called at posedge+1; drives one pixel for one cycle, then idles gap cycles.
    task automatic send_pix(input int val, input bit last, input int gap);
        int n = 0;
        while (!ready_a && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_a) chk("ready_timeout", ready_a, 1);
        pix_valid = 1'b1;
        pix_data = 8'(val);
        pix_last = last;
        model[val]++;
        if (last) push_frame();
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pix_last = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_dump();
        int n = 0;
        while (sb.size() > 0 && n < 800) begin
            @(posedge clk);
            n++;
        end
        chk("dump_done", sb.size(), 0);
        n = 0;
        while (!ready_a && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("ready_after_dump", ready_a, 1);
    endtask

    initial begin
        int vals[5];
        int n;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'($urandom);
            mem_b[i] = 4'($urandom);
        end

        do_reset();

        for (int i = 0; i < 4; i++) send_pix(5, i == 3, 0);
        wait_dump();

        vals = '{7, 9, 7, 9, 7};
        for (int i = 0; i < 5; i++) send_pix(vals[i], i == 4, 0);
        wait_dump();

        for (int i = 0; i < 6; i++) send_pix(3, i == 5, 1);
        wait_dump();

        for (int i = 0; i < 12; i++) send_pix(10, 1'b0, i % 4);
        for (int i = 0; i < 30; i++)
            send_pix(int'($urandom_range(20, 22)), i == 29, int'($urandom_range(0, 3)));
        wait_dump();

        for (int i = 0; i < 20; i++) send_pix(200, i == 19, 0);
        wait_dump();
        send_pix(200, 1'b1, 0);
        wait_dump();

        send_pix(0, 1'b1, 0);
        wait_dump();

        // frame whose dump is interrupted by reset while reading bin 100
        send_pix(10, 1'b0, 0);
        send_pix(11, 1'b0, 0);
        send_pix(12, 1'b1, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(hv_a && hb_a == 8'd97) && n < 600);
        chk("reach_bin97", hb_a, 97);
        do_reset();

        send_pix(1, 1'b0, 0);
        send_pix(2, 1'b1, 0);
        wait_dump();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
